// File: rtl/prefetch_queue_pkg.sv
// Shared constants and helpers for the prefetch queue: default geometry, counter width and saturation.
// Pure declarations, no timing; no flow control of its own.
package prefetch_queue_pkg;

  localparam int PFQ_DEFAULT_DEPTH = 8;
  localparam int PFQ_AW            = 16;
  localparam int CNT_W             = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/prefetch_queue_cam.sv
// Entry array with per-entry valid bits, parallel address compare, tail write and clear-by-mask.
// Writes/clears take effect at the next edge; compare and read ports are combinational; no backpressure.
module prefetch_queue_cam #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DEPTH-1:0]         clr_mask,
  input  logic [AW-1:0]            pf_addr,
  input  logic [AW-1:0]            demand_addr,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DEPTH-1:0]         pf_match,
  output logic [DEPTH-1:0]         dm_match,
  output logic                     rd_vld,
  output logic [AW-1:0]            rd_addr
);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] wr_oh;

  assign wr_oh = wr_en ? ({{(DEPTH-1){1'b0}}, 1'b1} << wr_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      // a write lands on a slot outside the queue, so it never collides with a clear
      vld_q <= (vld_q & ~clr_mask) | wr_oh;
      if (wr_en) addr_q[wr_idx] <= wr_addr;
    end
  end

  always_comb begin
    pf_match = '0;
    dm_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pf_match[i] = vld_q[i] && (addr_q[i] == pf_addr);
      dm_match[i] = vld_q[i] && (addr_q[i] == demand_addr);
    end
  end

  assign rd_vld  = vld_q[rd_idx];
  assign rd_addr = addr_q[rd_idx];

endmodule

// File: rtl/prefetch_queue.sv
// Prefetch candidate queue: dedups, demand-cancels and sheds load; issues via mem_valid/mem_ready.
// One-cycle enqueue-to-issue latency; mem_ready low holds head stable, full queue drops new candidates.
// Optional PFQ_STATS_EN macro enables the drop/filter counters (tied to zero otherwise).
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = PFQ_DEFAULT_DEPTH,
  parameter int AW    = PFQ_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pf_valid,
  input  logic [AW-1:0]          pf_addr,
  input  logic                   demand_valid,
  input  logic [AW-1:0]          demand_addr,
  output logic                   mem_valid,
  output logic [AW-1:0]          mem_addr,
  input  logic                   mem_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       drop_count,
  output logic [CNT_W-1:0]       filter_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      head_q, tail_q, occ;
  logic [DEPTH-1:0] pf_match, dm_match, head_oh, cancel, clr_mask;
  logic             head_vld, issue, bubble, pf_filt, pf_drop, enq;
  logic [AW-1:0]    head_addr;

  assign occ       = tail_q - head_q;
  assign occupancy = occ;
  assign mem_valid = (occ != '0) && head_vld;
  assign mem_addr  = head_addr;

  prefetch_queue_cam #(.DEPTH(DEPTH), .AW(AW)) u_cam (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (enq),
    .wr_idx      (tail_q[PW-1:0]),
    .wr_addr     (pf_addr),
    .clr_mask    (clr_mask),
    .pf_addr     (pf_addr),
    .demand_addr (demand_addr),
    .rd_idx      (head_q[PW-1:0]),
    .pf_match    (pf_match),
    .dm_match    (dm_match),
    .rd_vld      (head_vld),
    .rd_addr     (head_addr)
  );

  always_comb begin
    issue    = mem_valid && mem_ready;
    bubble   = (occ != '0) && !head_vld;
    head_oh  = {{(DEPTH-1){1'b0}}, 1'b1} << head_q[PW-1:0];
    // the head being handed to memory this cycle is not cancelled by a demand
    cancel   = demand_valid ? (dm_match & ~(issue ? head_oh : '0)) : '0;
    clr_mask = cancel | (issue ? head_oh : '0);
    pf_filt  = pf_valid && ((demand_valid && (demand_addr == pf_addr)) || (|pf_match));
    // full check uses pre-dequeue occupancy: a same-cycle issue does not make room
    pf_drop  = pf_valid && !pf_filt && (occ == (PW+1)'(DEPTH));
    enq      = pf_valid && !pf_filt && !pf_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (issue || bubble) head_q <= head_q + (PW+1)'(1);
      if (enq)             tail_q <= tail_q + (PW+1)'(1);
    end
  end

`ifdef PFQ_STATS_EN
  logic [CNT_W-1:0] drop_q, filt_q, filt_inc;

  always_comb begin
    filt_inc = {{(CNT_W-1){1'b0}}, pf_filt};
    for (int i = 0; i < DEPTH; i++) filt_inc = filt_inc + {{(CNT_W-1){1'b0}}, cancel[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
      filt_q <= '0;
    end else begin
      drop_q <= sat_add(drop_q, {{(CNT_W-1){1'b0}}, pf_drop});
      filt_q <= sat_add(filt_q, filt_inc);
    end
  end

  assign drop_count   = drop_q;
  assign filter_count = filt_q;
`else
  assign drop_count   = '0;
  assign filter_count = '0;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue; counter expectations follow PFQ_STATS_EN.
module tb_prefetch_queue;

`ifdef PFQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, pf_valid, demand_valid, mem_ready, mem_valid;
  logic [15:0] pf_addr, demand_addr, mem_addr, drop_count, filter_count;
  logic [3:0]  occupancy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prefetch_queue #(.DEPTH(8), .AW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .pf_valid     (pf_valid),
    .pf_addr      (pf_addr),
    .demand_valid (demand_valid),
    .demand_addr  (demand_addr),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .occupancy    (occupancy),
    .drop_count   (drop_count),
    .filter_count (filter_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pf(input logic [15:0] a);
    pf_valid = 1'b1;
    pf_addr  = a;
    step();
    pf_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pf_valid = 1'b0; pf_addr = '0;
    demand_valid = 1'b0; demand_addr = '0; mem_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_filt", 32'(filter_count), 0);

    // basic: enqueue, next-cycle visibility, enqueue+issue same cycle
    mem_ready = 1'b1;
    pf(16'h0010);
    chk("basic_vld0", 32'(mem_valid), 1);
    chk("basic_addr0", 32'(mem_addr), 32'h10);
    pf(16'h0011);
    chk("basic_occ1", 32'(occupancy), 1);
    chk("basic_addr1", 32'(mem_addr), 32'h11);
    step();
    chk("basic_occ_end", 32'(occupancy), 0);
    chk("basic_vld_end", 32'(mem_valid), 0);

    // backpressure and full
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) pf(16'h0100 + 16'(i));
    chk("full_occ", 32'(occupancy), 8);
    chk("full_addr", 32'(mem_addr), 32'h100);
    chk("full_drop", 32'(drop_count), STATS ? 2 : 0);
    step();
    chk("stall_vld", 32'(mem_valid), 1);
    chk("stall_addr", 32'(mem_addr), 32'h100);
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_vld", 32'(mem_valid), 1);
      chk("drain_addr", 32'(mem_addr), 32'h100 + 32'(i));
      step();
    end
    chk("drain_occ", 32'(occupancy), 0);

    // duplicate filter
    mem_ready = 1'b0;
    pf(16'h0020);
    pf(16'h0020);
    chk("dup_occ", 32'(occupancy), 1);
    chk("dup_filt", 32'(filter_count), STATS ? 1 : 0);
    mem_ready = 1'b1;
    step();
    chk("dup_drain", 32'(occupancy), 0);

    // demand cancel creates a bubble
    mem_ready = 1'b0;
    pf(16'h0030); pf(16'h0031); pf(16'h0032);
    demand_valid = 1'b1; demand_addr = 16'h0031;
    step();
    demand_valid = 1'b0;
    chk("dc_occ", 32'(occupancy), 3);
    chk("dc_filt", 32'(filter_count), STATS ? 2 : 0);
    mem_ready = 1'b1;
    chk("dc_addr0", 32'(mem_addr), 32'h30);
    step();
    chk("dc_bubble_vld", 32'(mem_valid), 0);
    chk("dc_bubble_occ", 32'(occupancy), 2);
    step();
    chk("dc_vld2", 32'(mem_valid), 1);
    chk("dc_addr2", 32'(mem_addr), 32'h32);
    step();
    chk("dc_occ_end", 32'(occupancy), 0);

    // full with simultaneous issue: candidate still dropped
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) pf(16'h0050 + 16'(i));
    chk("fi_occ8", 32'(occupancy), 8);
    mem_ready = 1'b1;
    pf(16'h0040);
    mem_ready = 1'b0;
    chk("fi_occ7", 32'(occupancy), 7);
    chk("fi_addr", 32'(mem_addr), 32'h51);
    chk("fi_drop", 32'(drop_count), STATS ? 3 : 0);

    // reset mid-operation
    mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    chk("rm_occ5", 32'(occupancy), 5);
    rst = 1'b1; pf_valid = 1'b1; pf_addr = 16'h0060;
    demand_valid = 1'b1; demand_addr = 16'h0053;
    step();
    rst = 1'b0; pf_valid = 1'b0; demand_valid = 1'b0;
    chk("rm_vld", 32'(mem_valid), 0);
    chk("rm_occ", 32'(occupancy), 0);
    chk("rm_addr", 32'(mem_addr), 0);
    chk("rm_drop", 32'(drop_count), 0);
    chk("rm_filt", 32'(filter_count), 0);
    step();
    chk("rm_occ_after", 32'(occupancy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
